tia_video_capture: RTL and testbench

//  Receive side of the TIA video timing interface: consumes composite sync (syn, active-low

---
 rtl/tia_video_capture.sv | 157 +++++++++++++++
 tb/tb_tia_video_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tia_video_capture.sv
// TIA composite-sync receiver: recovers x/y position and h/frame lock from syn, emits a pixel stream.
// Define TIA_CAPTURE_STATS_EN to build the saturating lock-loss counter on err_cnt.
module tia_video_capture #(
  parameter int LINE_LEN     = 228,
  parameter int HS_MIN       = 12,
  parameter int HS_MAX       = 20,
  parameter int VS_MIN       = 100,
  parameter int VS_LINES_MIN = 2,
  parameter int COLU_W       = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              syn,
  input  logic              blank,
  input  logic [COLU_W-1:0] colu,
  output logic [7:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic [COLU_W-1:0] pix_colu,
  output logic              pix_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic [1:0]        lock_state,
  output logic [8:0]        frame_lines,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_HLOCK    = 2'd1,
    ST_FLOCK    = 2'd2
  } state_e;

  localparam logic [7:0] HS_MIN_C   = 8'(HS_MIN);
  localparam logic [7:0] HS_MAX_C   = 8'(HS_MAX);
  localparam logic [7:0] VS_MIN_C   = 8'(VS_MIN);
  localparam logic [7:0] VS_LINES_C = 8'(VS_LINES_MIN);
  localparam logic [8:0] LINE_LEN_C = 9'(LINE_LEN);
  localparam logic [8:0] TMO_C      = 9'(LINE_LEN + HS_MAX);

  state_e              state_q, state_d;
  logic                syn_q, syn_d;
  logic [7:0]          lo_cnt_q, lo_cnt_d;
  logic [8:0]          pos_q, pos_d;
  logic [8:0]          pix_y_q, pix_y_d;
  logic [COLU_W-1:0]   pix_colu_q, pix_colu_d;
  logic                pix_valid_q, pix_valid_d;
  logic                line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d;
  logic [8:0]          frame_lines_q, frame_lines_d;
  logic [7:0]          vs_cnt_q, vs_cnt_d;
  logic                have_prev_q, have_prev_d;

  logic rise, vs_w, hs_evt, vs_evt, per_ok, timeout;

  always_comb begin
    syn_d   = syn;
    rise    = syn_q && (lo_cnt_q != 8'd0);
    vs_w    = lo_cnt_q >= VS_MIN_C;
    hs_evt  = rise && (((lo_cnt_q >= HS_MIN_C) && (lo_cnt_q <= HS_MAX_C)) || vs_w);
    vs_evt  = rise && vs_w;
    // Period is measured falling-edge to falling-edge so sync width changes (vsync) don't skew it.
    per_ok  = have_prev_q && (pos_q == LINE_LEN_C + {1'b0, lo_cnt_q});
    // A sync pulse in progress defers the timeout until its width is known.
    timeout = syn_q && (pos_q >= TMO_C);

    lo_cnt_d      = syn_q ? 8'd0 : ((lo_cnt_q == 8'hFF) ? lo_cnt_q : lo_cnt_q + 8'd1);
    pos_d         = (pos_q == 9'h1FF) ? pos_q : pos_q + 9'd1;
    pix_y_d       = pix_y_q;
    pix_colu_d    = colu;
    line_start_d  = hs_evt;
    frame_start_d = 1'b0;
    frame_lines_d = frame_lines_q;
    vs_cnt_d      = vs_cnt_q;
    have_prev_d   = have_prev_q;
    state_d       = state_q;

    if (hs_evt) begin
      pos_d       = {1'b0, lo_cnt_q} + 9'd1;
      pix_y_d     = (pix_y_q == 9'h1FF) ? pix_y_q : pix_y_q + 9'd1;
      have_prev_d = 1'b1;
      if (vs_evt) vs_cnt_d = (vs_cnt_q == 8'hFF) ? vs_cnt_q : vs_cnt_q + 8'd1;
      else        vs_cnt_d = 8'd0;
      if (!per_ok) begin
        state_d = ST_UNLOCKED;
      end else if (state_q == ST_UNLOCKED) begin
        state_d = ST_HLOCK;
      end else if (!vs_evt && (vs_cnt_q >= VS_LINES_C)) begin
        state_d       = ST_FLOCK;
        frame_start_d = 1'b1;
        frame_lines_d = (pix_y_q == 9'h1FF) ? pix_y_q : pix_y_q + 9'd1;
        pix_y_d       = 9'd0;
      end
    end else if (timeout) begin
      state_d     = ST_UNLOCKED;
      have_prev_d = 1'b0;
    end

    pix_valid_d = (state_d == ST_FLOCK) && !blank;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_UNLOCKED;
      syn_q         <= 1'b1;
      lo_cnt_q      <= '0;
      pos_q         <= '0;
      pix_y_q       <= '0;
      pix_colu_q    <= '0;
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_lines_q <= '0;
      vs_cnt_q      <= '0;
      have_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      syn_q         <= syn_d;
      lo_cnt_q      <= lo_cnt_d;
      pos_q         <= pos_d;
      pix_y_q       <= pix_y_d;
      pix_colu_q    <= pix_colu_d;
      pix_valid_q   <= pix_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_lines_q <= frame_lines_d;
      vs_cnt_q      <= vs_cnt_d;
      have_prev_q   <= have_prev_d;
    end
  end

  assign pix_x       = pos_q[8] ? 8'hFF : pos_q[7:0];
  assign pix_y       = pix_y_q;
  assign pix_colu    = pix_colu_q;
  assign pix_valid   = pix_valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign lock_state  = state_q;
  assign frame_lines = frame_lines_q;

`ifdef TIA_CAPTURE_STATS_EN
  logic       lock_loss;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign lock_loss = (state_q != ST_UNLOCKED) && (state_d == ST_UNLOCKED);
  assign err_cnt_d = (lock_loss && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tia_video_capture.sv
// Bench for tia_video_capture: line-level scoreboard for line_start events plus a per-clock pixel scoreboard.
module tb_tia_video_capture;

`ifdef TIA_CAPTURE_STATS_EN
  localparam int ERR_INC = 1;
`else
  localparam int ERR_INC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       syn;
  logic       blank;
  logic [6:0] colu;
  logic [7:0] pix_x;
  logic [8:0] pix_y;
  logic [6:0] pix_colu;
  logic       pix_valid;
  logic       line_start;
  logic       frame_start;
  logic [1:0] lock_state;
  logic [8:0] frame_lines;
  logic [7:0] err_cnt;

  tia_video_capture dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .syn         (syn),
    .blank       (blank),
    .colu        (colu),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colu    (pix_colu),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .lock_state  (lock_state),
    .frame_lines (frame_lines),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [8:0] y;
    logic [1:0] lock;
    logic       fs;
    logic [8:0] fl;
  } line_exp_t;

  typedef struct {
    logic       vld;
    logic [6:0] colu;
    logic [7:0] x;
  } pix_exp_t;

  line_exp_t exp_q[$];
  pix_exp_t  pix_q[$];
  line_exp_t mon_e;
  pix_exp_t  mon_p;
  int        n_checks = 0;
  int        n_errors = 0;
  int        fs_cnt   = 0;
  int        exp_y    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled 1 time unit after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (line_start) begin
      if (exp_q.size() == 0) begin
        check("spurious_line_start", 32'(line_start), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ls_pix_x", 32'(pix_x), 32'(mon_e.x));
        check("ls_pix_y", 32'(pix_y), 32'(mon_e.y));
        check("ls_lock", 32'(lock_state), 32'(mon_e.lock));
        check("ls_frame_start", 32'(frame_start), 32'(mon_e.fs));
        if (mon_e.fs) check("ls_frame_lines", 32'(frame_lines), 32'(mon_e.fl));
      end
    end else if (frame_start) begin
      check("frame_start_without_line", 32'(frame_start), 32'd0);
    end
    if (pix_q.size() != 0) begin
      mon_p = pix_q.pop_front();
      check("pix_valid", 32'(pix_valid), 32'(mon_p.vld));
      check("pix_colu", 32'(pix_colu), 32'(mon_p.colu));
      check("pix_x_run", 32'(pix_x), 32'(mon_p.x));
    end
  end

  // One scanline starting at the sync falling edge: w clocks low, len clocks total.
  task automatic drive_line(input int w, input int len, input int glitch_at, input bit pixchk);
    pix_exp_t p;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (glitch_at >= 0 && i == glitch_at + 50)
        check("x_after_glitch", 32'(pix_x), 32'(i - 1));
      syn   = !((i < w) || (glitch_at >= 0 && i >= glitch_at && i < glitch_at + 5));
      blank = (i < 68);
      colu  = (i < 68) ? 7'h55 : 7'h2A;
      if (pixchk) begin
        p.vld  = (i >= 68);
        p.colu = colu;
        p.x    = (i <= w) ? 8'(228 + i) : 8'(i);
        pix_q.push_back(p);
      end
    end
  endtask

  task automatic line(input int w, input int len, input logic [1:0] lock_exp, input bit boundary,
                      input int glitch_at, input bit pixchk);
    line_exp_t e;
    if (boundary) begin
      e.fl  = 9'(exp_y + 1);
      exp_y = 0;
    end else begin
      e.fl  = 9'd0;
      exp_y = (exp_y < 511) ? exp_y + 1 : 511;
    end
    e.x    = 8'(w + 1);
    e.y    = 9'(exp_y);
    e.lock = lock_exp;
    e.fs   = boundary;
    exp_q.push_back(e);
    drive_line(w, len, glitch_at, pixchk);
  endtask

  initial begin
    reset_n = 1'b0;
    syn     = 1'b1;
    blank   = 1'b0;
    colu    = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      syn   = ~syn;
      colu  = 7'(i * 19);
      blank = i[0];
    end
    @(negedge clk);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_pix_colu", 32'(pix_colu), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_line_start", 32'(line_start), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_lock", 32'(lock_state), 32'd0);
    check("rst_frame_lines", 32'(frame_lines), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    syn     = 1'b1;
    blank   = 1'b0;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // Horizontal lock after two correctly spaced hsyncs, then a mid-line glitch.
    line(16, 228, 2'd0, 1'b0, -1, 1'b0);
    line(16, 228, 2'd1, 1'b0, -1, 1'b0);
    line(16, 228, 2'd1, 1'b0, 100, 1'b0);
    check("lock_after_glitch", 32'(lock_state), 32'd1);

    // Vertical sync block then first frame boundary (6 lines counted before it).
    for (int k = 0; k < 3; k++) line(212, 228, 2'd1, 1'b0, -1, 1'b0);
    line(16, 228, 2'd2, 1'b1, -1, 1'b0);
    check("lock_flock", 32'(lock_state), 32'd2);

    // Full 262-line frame; one visible line is checked pixel by pixel.
    for (int k = 0; k < 258; k++) line(16, 228, 2'd2, 1'b0, -1, (k == 5));
    for (int k = 0; k < 3; k++) line(212, 228, 2'd2, 1'b0, -1, 1'b0);
    line(16, 228, 2'd2, 1'b1, -1, 1'b0);
    check("frame_lines_262", 32'(frame_lines), 32'd262);

    // Short line breaks the period: lock lost at the following hsync.
    line(16, 227, 2'd2, 1'b0, -1, 1'b0);
    line(16, 228, 2'd0, 1'b0, -1, 1'b0);
    check("err_after_period_loss", 32'(err_cnt), 32'(ERR_INC));
    line(16, 228, 2'd1, 1'b0, -1, 1'b0);

    // Missing hsync: timeout drops lock.
    repeat (300) @(negedge clk);
    check("lock_after_timeout", 32'(lock_state), 32'd0);
    check("err_after_timeout", 32'(err_cnt), 32'(2 * ERR_INC));
    line(16, 228, 2'd0, 1'b0, -1, 1'b0);
    line(16, 228, 2'd1, 1'b0, -1, 1'b0);

    // Asynchronous reset in the middle of a line.
    line(16, 100, 2'd1, 1'b0, -1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_pix_x", 32'(pix_x), 32'd0);
    check("midrst_pix_y", 32'(pix_y), 32'd0);
    check("midrst_lock", 32'(lock_state), 32'd0);
    check("midrst_frame_lines", 32'(frame_lines), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    syn = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_y   = 0;
    line(16, 228, 2'd0, 1'b0, -1, 1'b0);
    line(16, 228, 2'd1, 1'b0, -1, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_line_exp", 32'(exp_q.size()), 32'd0);
    check("pending_pix_exp", 32'(pix_q.size()), 32'd0);
    check("frame_start_pulses", 32'(fs_cnt), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
